// File: rtl/snd_mix_pkg.sv
// Shared types and helpers for the DAC mixer: volume table, FSM states, accumulator sizing.
package snd_mix_pkg;

  typedef enum logic [1:0] {StIdle, StSnap, StMac, StOut} mix_state_e;

  // Index 0 is loudest.
  function automatic logic [7:0] vol_scale(input logic [3:0] idx);
    logic [7:0] s;
    case (idx)
      4'd0:    s = 8'd255;
      4'd1:    s = 8'd200;
      4'd2:    s = 8'd160;
      4'd3:    s = 8'd140;
      4'd4:    s = 8'd128;
      4'd5:    s = 8'd112;
      4'd6:    s = 8'd100;
      4'd7:    s = 8'd90;
      4'd8:    s = 8'd80;
      4'd9:    s = 8'd72;
      4'd10:   s = 8'd64;
      4'd11:   s = 8'd56;
      4'd12:   s = 8'd48;
      4'd13:   s = 8'd40;
      4'd14:   s = 8'd32;
      default: s = 8'd24;
    endcase
    return s;
  endfunction

  function automatic int unsigned acc_w(input int unsigned nch, input int unsigned dac_w,
                                        input int unsigned scale_w);
    return dac_w + scale_w + 1 + $clog2(nch);
  endfunction

endpackage

// File: rtl/snd_vol_ramp.sv
// Single volume ramper: walks the current scale toward its target by a bounded step per tick.
module snd_vol_ramp
  import snd_mix_pkg::*;
#(
  parameter int unsigned SCALE_W   = 8,
  parameter int unsigned RAMP_STEP = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SCALE_W-1:0] target,
  input  logic               tick,
  input  logic               pause,
  output logic [SCALE_W-1:0] cur
);

  localparam logic [SCALE_W-1:0] Step = SCALE_W'(RAMP_STEP);

  logic [SCALE_W-1:0] cur_q, cur_d, diff;

  always_comb begin
    cur_d = cur_q;
    diff  = (target > cur_q) ? (target - cur_q) : (cur_q - target);
    if (tick && !pause) begin
      if (diff <= Step) begin
        cur_d = target;
      end else if (target > cur_q) begin
        cur_d = cur_q + Step;
      end else begin
        cur_d = cur_q - Step;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_q <= '0;
    end else begin
      cur_q <= cur_d;
    end
  end

  assign cur = cur_q;

endmodule

// File: rtl/snd_dac_mixer.sv
// NCH-source stereo DAC mixer: ramped per-source volumes, one time-shared multiplier per sample,
// saturated signed stereo output with a one-cycle strobe.
module snd_dac_mixer
  import snd_mix_pkg::*;
#(
  parameter int unsigned NCH        = 2,
  parameter int unsigned DAC_W      = 8,
  parameter int unsigned VOL_W      = 4,
  parameter int unsigned SCALE_W    = 8,
  parameter int unsigned OUT_W      = 16,
  parameter int unsigned SAMPLE_DIV = 455,
  parameter int unsigned RAMP_DIV   = 2048,
  parameter int unsigned RAMP_STEP  = 4
) (
  input  logic                   clk_20m,
  input  logic                   reset,
  input  logic [NCH*DAC_W-1:0]   dac_val,
  input  logic [NCH-1:0]         dac_wr,
  input  logic [NCH*2*VOL_W-1:0] vol_idx,
  input  logic                   pause,
  output logic                   sample_stb,
  output logic [OUT_W-1:0]       audio_l,
  output logic [OUT_W-1:0]       audio_r
);

  localparam int unsigned NSrc  = 2 * NCH;
  localparam int unsigned AccW  = acc_w(NCH, DAC_W, SCALE_W);
  localparam int unsigned ProdW = DAC_W + SCALE_W + 1;
  localparam int unsigned StepW = $clog2(NSrc);
  localparam int unsigned SCntW = $clog2(SAMPLE_DIV + 1);
  localparam int unsigned RCntW = $clog2(RAMP_DIV + 1);
  localparam logic [DAC_W-1:0] Mid = DAC_W'(1 << (DAC_W - 1));
  localparam logic [StepW-1:0] LastStep = StepW'(NSrc - 1);
  localparam longint SatHi = (longint'(1) << (OUT_W - 1)) - 1;
  localparam longint SatLo = -SatHi - 1;

  if (NCH < 1 || NCH > 8 || SAMPLE_DIV < 2 * NCH + 2) begin : g_bad_params
    $error("snd_dac_mixer: NCH must be 1..8 and SAMPLE_DIV >= 2*NCH+2");
  end

  function automatic logic [OUT_W-1:0] sat(input logic signed [AccW-1:0] a);
    longint v;
    v = longint'(a);
    if (v > SatHi) v = SatHi;
    else if (v < SatLo) v = SatLo;
    return OUT_W'(v);
  endfunction

  logic [NCH*DAC_W-1:0]    latch_q, snap_dac_q;
  logic [NSrc*SCALE_W-1:0] scale_cur, snap_scale_q;
  logic [RCntW-1:0]        rcnt_q;
  logic [SCntW-1:0]        scnt_q;
  logic                    ramp_tick, snap_en;
  mix_state_e              state_q, state_d;
  logic [StepW-1:0]        step_q, step_d;
  logic signed [AccW-1:0]  acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [OUT_W-1:0]        aud_l_q, aud_l_d, aud_r_q, aud_r_d;
  logic signed [ProdW-1:0] smp_x, scl_x, prod;

  always_ff @(posedge clk_20m) begin
    for (int i = 0; i < NCH; i++) begin
      if (reset) begin
        latch_q[i*DAC_W +: DAC_W] <= Mid;
      end else if (dac_wr[i]) begin
        latch_q[i*DAC_W +: DAC_W] <= dac_val[i*DAC_W +: DAC_W];
      end
    end
  end

  assign ramp_tick = !pause && (rcnt_q == RCntW'(RAMP_DIV - 1));

  always_ff @(posedge clk_20m) begin
    if (reset) begin
      rcnt_q <= '0;
      scnt_q <= '0;
    end else if (!pause) begin
      rcnt_q <= ramp_tick ? '0 : rcnt_q + RCntW'(1);
      scnt_q <= (scnt_q == SCntW'(SAMPLE_DIV - 1)) ? '0 : scnt_q + SCntW'(1);
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_src
    logic [SCALE_W-1:0] tgt_l, tgt_r;
    assign tgt_l = SCALE_W'(vol_scale(4'(vol_idx[c*2*VOL_W+VOL_W +: VOL_W])));
    assign tgt_r = SCALE_W'(vol_scale(4'(vol_idx[c*2*VOL_W +: VOL_W])));

    snd_vol_ramp #(.SCALE_W(SCALE_W), .RAMP_STEP(RAMP_STEP)) u_ramp_l (
      .clk   (clk_20m),
      .reset (reset),
      .target(tgt_l),
      .tick  (ramp_tick),
      .pause (pause),
      .cur   (scale_cur[(2*c)*SCALE_W +: SCALE_W])
    );

    snd_vol_ramp #(.SCALE_W(SCALE_W), .RAMP_STEP(RAMP_STEP)) u_ramp_r (
      .clk   (clk_20m),
      .reset (reset),
      .target(tgt_r),
      .tick  (ramp_tick),
      .pause (pause),
      .cur   (scale_cur[(2*c+1)*SCALE_W +: SCALE_W])
    );
  end

  // Shared multiplier: step k handles source k/2, left on even steps, right on odd.
  always_comb begin
    int unsigned ch;
    logic [DAC_W-1:0] d;
    ch    = 32'(step_q >> 1);
    d     = snap_dac_q[ch*DAC_W +: DAC_W];
    smp_x = ProdW'($signed({~d[DAC_W-1], d[DAC_W-2:0]}));
    scl_x = ProdW'({1'b0, snap_scale_q[32'(step_q)*SCALE_W +: SCALE_W]});
    prod  = smp_x * scl_x;
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    acc_l_d = acc_l_q;
    acc_r_d = acc_r_q;
    aud_l_d = aud_l_q;
    aud_r_d = aud_r_q;
    snap_en = 1'b0;
    if (!pause) begin
      unique case (state_q)
        StIdle: if (scnt_q == SCntW'(SAMPLE_DIV - 2)) state_d = StSnap;
        StSnap: begin
          snap_en = 1'b1;
          acc_l_d = '0;
          acc_r_d = '0;
          step_d  = '0;
          state_d = StMac;
        end
        StMac: begin
          if (step_q[0]) acc_r_d = acc_r_q + AccW'(prod);
          else acc_l_d = acc_l_q + AccW'(prod);
          if (step_q == LastStep) begin
            aud_l_d = sat(acc_l_d);
            aud_r_d = sat(acc_r_d);
            state_d = StOut;
          end else begin
            step_d = step_q + StepW'(1);
          end
        end
        StOut:   state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_20m) begin
    if (reset) begin
      state_q <= StIdle;
      step_q  <= '0;
      acc_l_q <= '0;
      acc_r_q <= '0;
      aud_l_q <= '0;
      aud_r_q <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      acc_l_q <= acc_l_d;
      acc_r_q <= acc_r_d;
      aud_l_q <= aud_l_d;
      aud_r_q <= aud_r_d;
    end
  end

  // Snapshot registers are pure datapath; they are always written before use.
  always_ff @(posedge clk_20m) begin
    if (snap_en) begin
      snap_dac_q   <= latch_q;
      snap_scale_q <= scale_cur;
    end
  end

  assign sample_stb = (state_q == StOut) && !pause;
  assign audio_l    = aud_l_q;
  assign audio_r    = aud_r_q;

endmodule

// File: doc/snd_dac_mixer.md
Name: snd_dac_mixer

Overview:
Parametrised DAC output stage for the audio board, generalising the single-DAC stereo attenuator to NCH independent 8-bit DAC sources. Each source has its own left and right volume index. Volume changes ramp toward their target so there is no zipper noise. One time-shared multiplier per sample computes signed, saturated stereo sums. Sits between the sound PIAs/DAC latches and the top-level audio_l/audio_r outputs.

Parameters:
NCH, 2, number of DAC sources (1..8)
DAC_W, 8, DAC sample width, offset-binary
VOL_W, 4, volume index width; index 0 = loudest
SCALE_W, 8, scale factor width
OUT_W, 16, signed output width
SAMPLE_DIV, 455, clk cycles per output sample (20 MHz / 455 ≈ 43.96 kHz); must be >= 2*NCH+2
RAMP_DIV, 2048, clk cycles per ramp tick
RAMP_STEP, 4, max scale change per ramp tick

Ports:
clk_20m  in  1  system clock
reset  in  1  synchronous, active-high reset
dac_val  in  NCH*DAC_W  per-source DAC value; source i is at [i*DAC_W +: DAC_W]
dac_wr  in  NCH  per-source write strobe; latches dac_val slice
vol_idx  in  NCH*2*VOL_W  per-source {left,right} index; source i left at [i*2*VOL_W+VOL_W +: VOL_W], right at [i*2*VOL_W +: VOL_W]
pause  in  1  freezes sample and ramp counters
sample_stb  out  1  one-cycle pulse when audio_l/audio_r update
audio_l  out  OUT_W  signed left output
audio_r  out  OUT_W  signed right output

Behaviour:
- Reset (sync, active-high) applies to the block's state:
  - audio_l, audio_r, sample_stb = 0.
  - DAC latches = 2^(DAC_W-1), i.e. midpoint.
  - All current scales = 0.
  - Sample counter and ramp counter = 0; FSM = IDLE.
  - A reset asserted mid-sequence aborts the sequence; no strobe is issued.
- DAC latch: on dac_wr[i], latch[i] <= slice i, the cycle after the strobe. This is independent of the FSM.
- Volume target: target = VOL_TABLE[idx], a 16-entry table (255,200,160,140,128,112,100,90,80,72,64,56,48,40,32,24).
- Ramp, one ramper per source per side (2*NCH total):
  - Ramp tick when the ramp counter reaches RAMP_DIV-1; the counter then wraps.
  - On a tick: if |target-cur| <= RAMP_STEP then cur <= target; else cur moves by RAMP_STEP toward target.
  - A target change takes effect on the next tick.
- Sample counter counts 0..SAMPLE_DIV-1 and wraps.
- FSM:
  - IDLE -> SNAP when the counter reaches SAMPLE_DIV-1 (cycle T). SNAP copies all latches and current scales into snapshot registers, so later dac_wr or ramp ticks affect only the next sample. Accumulators are cleared.
  - SNAP -> MAC at T+1. MAC runs 2*NCH cycles (T+1..T+2NCH), processing order ch0 L, ch0 R, ch1 L, and so on.
  - Each MAC step: s = latch - 2^(DAC_W-1), signed in -128..127; p = s * scale, signed, DAC_W+SCALE_W+1 bits; acc += p.
  - Accumulator width = DAC_W+SCALE_W+1+clog2(NCH); it never overflows.
  - MAC -> OUT. At T+2NCH+1, audio_l and audio_r <= saturate(acc) to OUT_W (clamp to +2^(OUT_W-1)-1 / -2^(OUT_W-1)), and sample_stb = 1. Then OUT -> IDLE.
  - Outputs hold between strobes.
- pause=1 freezes the sample counter, ramp counter, FSM (any in-progress state holds) and scales. Outputs hold, sample_stb = 0. dac_wr latching still works while paused.
- Simultaneous events:
  - A ramp tick in the same cycle as SNAP: the snapshot takes the pre-tick scale.
  - dac_wr in the same cycle as SNAP: the snapshot takes the old latch value.
- Elaboration error if SAMPLE_DIV < 2*NCH+2 or NCH > 8.

Decomposition:
- Package snd_mix_pkg holds:
  - VOL_TABLE, as a function vol_scale(idx);
  - the FSM state enum (IDLE, SNAP, MAC, OUT);
  - the acc_w(NCH) width helper.
- Sub-module snd_vol_ramp: one scale ramper (target, tick, pause, cur); instantiated 2*NCH times.

Test Plan:
- Reset check: assert reset 3 cycles, release. Outputs stay 0 until the first sample_stb at cycle 455+2*2+1-1 counted from release (T=454, strobe at T+5=459). With all scales 0, the strobe carries output 0.
- Full scale: set vol_idx all 0 and wait 64 ramp ticks (scale reaches 255).
  - dac0=dac1=255 -> 2*32385 = 64770, saturates to audio_l = audio_r = 32767.
  - dac0=dac1=0 -> -65280 -> -32768.
- Mixed: dac0=255, dac1=0, vol 0 -> 32385-32640 = -255 on both sides.
- Stereo independence: NCH=1, vol_idx={0,15}, dac=255, after full ramp -> audio_l = 32385, audio_r = 127*24 = 3048.
- Ramp down: scale at 255, change idx 0 -> 15. After 57 ticks scale = 27; after the 58th tick scale = 24, and it stays there.
- Edge cases:
  - dac_wr in the SNAP cycle: the old value is used, the new value appears in the next sample.
  - pause mid-MAC for 100 cycles: the strobe is delayed by exactly 100 cycles and the result is unchanged.
  - reset mid-MAC: no strobe, outputs 0.
